// File: rtl/mux_scan_n.sv
// mux_scan_n: N_CH-channel, WIDTH-bit registered multiplexer with manual and
// auto-scan channel selection.
//
// In MANUAL mode the channel comes from s_i. Out-of-range selects are ignored,
// and the current channel is kept. In SCAN mode an internal sequencer steps
// through channels 0..N_CH-1 and stays DWELL cycles on each one. The output
// z_o is registered. strobe_o pulses for one cycle whenever the select changes,
// so downstream capture logic can sample once per channel.
//
// Ports:
//   clk_i     rising-edge clock
//   rst_i     asynchronous, active-high reset
//   c_i       channel data, channel k = c_i[k*WIDTH +: WIDTH]
//   s_i       manual select
//   mode_i    0 = MANUAL, 1 = SCAN
//   en_i      1 = select may change, 0 = select and dwell counter frozen
//   z_o       registered data of the selected channel
//   s_cur_o   select currently driving z_o
//   strobe_o  one-cycle pulse: s_cur_o took a new value this cycle
module mux_scan_n #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 1,
  parameter int DWELL = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [N_CH*WIDTH-1:0]     c_i,
  input  logic [$clog2(N_CH)-1:0]   s_i,
  input  logic                      mode_i,
  input  logic                      en_i,
  output logic [WIDTH-1:0]          z_o,
  output logic [$clog2(N_CH)-1:0]   s_cur_o,
  output logic                      strobe_o
);

  localparam int SEL_W = $clog2(N_CH);
  localparam int CNT_W = $clog2(DWELL + 1);

  // One extra bit so that N_CH itself is representable for the range check.
  localparam logic [SEL_W:0]   N_CH_L   = (SEL_W + 1)'(N_CH);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_CH - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_SCAN   = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SEL_W-1:0]       s_cur_q, next_sel_s;
  logic [WIDTH-1:0]       z_q;
  logic                   strobe_q;
  logic [WIDTH-1:0]       ch_s [N_CH];

  // Unpack the flat channel bus into an array indexed by select.
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign ch_s[k] = c_i[k*WIDTH +: WIDTH];
  end

  // Next select, dwell counter and next state.
  always_comb begin
    next_sel_s = s_cur_q;
    cnt_d      = cnt_q;
    if (mode_i) begin
      state_d = ST_SCAN;
    end else begin
      state_d = ST_MANUAL;
    end

    if (!en_i) begin
      // Frozen: the select and the counter hold. The state still follows mode_i.
      next_sel_s = s_cur_q;
      cnt_d      = cnt_q;
    end else if (!mode_i) begin
      cnt_d = '0;
      if ({1'b0, s_i} < N_CH_L) begin
        next_sel_s = s_i;
      end else begin
        next_sel_s = s_cur_q;
      end
    end else begin
      case (state_q)
        ST_SCAN: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (s_cur_q == LAST_SEL) begin
              next_sel_s = '0;
            end else begin
              next_sel_s = s_cur_q + SEL_W'(1);
            end
          end else begin
            cnt_d      = cnt_q + CNT_W'(1);
            next_sel_s = s_cur_q;
          end
        end
        default: begin
          // First cycle in SCAN: restart the dwell count on the current channel.
          cnt_d      = '0;
          next_sel_s = s_cur_q;
        end
      endcase
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_MANUAL;
      cnt_q    <= '0;
      s_cur_q  <= '0;
      z_q      <= '0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      s_cur_q  <= next_sel_s;
      z_q      <= ch_s[next_sel_s];
      strobe_q <= (next_sel_s != s_cur_q);
    end
  end

  assign z_o      = z_q;
  assign s_cur_o  = s_cur_q;
  assign strobe_o = strobe_q;

endmodule

// File: tb/tb_mux_scan_n.sv
// Testbench for mux_scan_n.
//
// Two instances are used:
//   dut_a has the default parameters (N_CH=4, WIDTH=1, DWELL=4).
//   dut_b has N_CH=3, WIDTH=4 and DWELL=1 (non-power-of-2, step every cycle).
//
// The bench runs three kinds of test:
//   - table vectors
//   - hand-written multi-cycle sequences
//   - randomized traffic checked against a channel/dwell-arithmetic model
module tb_mux_scan_n;

  logic        clk = 1'b0;
  logic        rst;

  logic [3:0]  c_a;
  logic [1:0]  s_a;
  logic        mode_a, en_a;
  logic [0:0]  z_a;
  logic [1:0]  scur_a;
  logic        strobe_a;

  logic [11:0] c_b;
  logic [1:0]  s_b;
  logic        mode_b, en_b;
  logic [3:0]  z_b;
  logic [1:0]  scur_b;
  logic        strobe_b;

  int checks   = 0;
  int failures = 0;

  mux_scan_n dut_a (
    .clk_i(clk), .rst_i(rst), .c_i(c_a), .s_i(s_a), .mode_i(mode_a), .en_i(en_a),
    .z_o(z_a), .s_cur_o(scur_a), .strobe_o(strobe_a)
  );

  mux_scan_n #(.N_CH(3), .WIDTH(4), .DWELL(1)) dut_b (
    .clk_i(clk), .rst_i(rst), .c_i(c_b), .s_i(s_b), .mode_i(mode_b), .en_i(en_b),
    .z_o(z_b), .s_cur_o(scur_b), .strobe_o(strobe_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          dut;
    bit          mode;
    bit          en;
    logic [1:0]  s;
    logic [11:0] c;
    int          scur;
    int          z;
    bit          strobe;
  } vec_t;

  vec_t vecs[$];

  // Reference model state, one slot per instance:
  // current select, channel at scan entry, enabled scan cycles since entry,
  // and previous mode.
  int m_sel   [2];
  int m_base  [2];
  int m_ticks [2];
  bit m_prev  [2];

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input bit dut, input int e_scur,
                           input int e_z, input bit e_strobe);
    if (!dut) begin
      check_val({name, ".s_cur"},  32'(scur_a),   e_scur);
      check_val({name, ".z"},      32'(z_a),      e_z);
      check_val({name, ".strobe"}, 32'(strobe_a), 32'(e_strobe));
    end else begin
      check_val({name, ".s_cur"},  32'(scur_b),   e_scur);
      check_val({name, ".z"},      32'(z_b),      e_z);
      check_val({name, ".strobe"}, 32'(strobe_b), 32'(e_strobe));
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic int chan(input logic [11:0] c, input int sel, input int w);
    return int'((c >> (sel * w)) & 12'((1 << w) - 1));
  endfunction

  // One clock edge of the spec rules. In scan mode the select is
  // base + floor(ticks / dwell), taken modulo the channel count.
  task automatic model_step(input int id, input int n, input int d, input bit mode,
                            input bit en, input int s, output bit strobe);
    int old;
    old = m_sel[id];
    if (en) begin
      if (!mode) begin
        if (s < n) m_sel[id] = s;
      end else if (!m_prev[id]) begin
        m_base[id]  = m_sel[id];
        m_ticks[id] = 0;
      end else begin
        m_ticks[id] = m_ticks[id] + 1;
        m_sel[id]   = (m_base[id] + m_ticks[id] / d) % n;
      end
    end
    m_prev[id] = mode;
    strobe = (m_sel[id] != old);
  endtask

  initial begin
    bit st_a, st_b;
    c_a = 4'h0; s_a = 2'd0; mode_a = 1'b0; en_a = 1'b0;
    c_b = 12'h000; s_b = 2'd0; mode_b = 1'b0; en_b = 1'b0;
    do_reset();
    check_out("reset_a", 1'b0, 0, 0, 1'b0);
    check_out("reset_b", 1'b1, 0, 0, 1'b0);

    // Manual selection on the 4:1 instance (c=0101), then out-of-range handling
    // and a short scan with wrap on the 3-channel instance.
    vecs.push_back('{1'b0, 1'b0, 1'b1, 2'd0, 12'h005, 0, 1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 2'd1, 12'h005, 1, 0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 2'd1, 12'h005, 1, 0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 2'd2, 12'h005, 2, 1, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 2'd3, 12'h005, 3, 0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 2'd0, 12'h005, 0, 1, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 2'd2, 12'h005, 0, 1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 2'd2, 12'h005, 2, 1, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 2'd2, 12'h00A, 2, 0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 2'd1, 12'hCBA, 1, 11, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 2'd3, 12'hCBA, 1, 11, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 2'd2, 12'hCBA, 2, 12, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 2'd3, 12'hCBA, 2, 12, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 2'd3, 12'hCBA, 2, 12, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 2'd3, 12'hCBA, 0, 10, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 2'd3, 12'hCBA, 1, 11, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 2'd3, 12'hCBA, 2, 12, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 2'd3, 12'hCBA, 0, 10, 1'b1});

    foreach (vecs[i]) begin
      if (!vecs[i].dut) begin
        mode_a = vecs[i].mode; en_a = vecs[i].en; s_a = vecs[i].s; c_a = vecs[i].c[3:0];
      end else begin
        mode_b = vecs[i].mode; en_b = vecs[i].en; s_b = vecs[i].s; c_b = vecs[i].c;
      end
      tick();
      check_out($sformatf("vec%0d", i), vecs[i].dut, vecs[i].scur, vecs[i].z, vecs[i].strobe);
    end

    // Scan from reset: 4 cycles per channel, wrap 3->0 with strobe.
    mode_a = 1'b0; en_a = 1'b0; mode_b = 1'b0; en_b = 1'b0;
    do_reset();
    c_a = 4'b0101; s_a = 2'd0; mode_a = 1'b1; en_a = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      int sel;
      sel = ((i - 1) / 4) % 4;
      tick();
      check_out($sformatf("scan%0d", i), 1'b0, sel, (5 >> sel) & 1,
                (i > 1) && ((i - 1) % 4 == 0));
    end

    // Freeze at s_cur=2 with the dwell count at 1, toggling channel 2.
    mode_a = 1'b0; en_a = 1'b0;
    do_reset();
    c_a = 4'b0101; mode_a = 1'b1; en_a = 1'b1;
    repeat (10) tick();
    check_val("freeze_pre.s_cur", 32'(scur_a), 2);
    en_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      c_a[2] = ~c_a[2];
      tick();
      check_out($sformatf("freeze%0d", i), 1'b0, 2, int'(c_a[2]), 1'b0);
    end
    en_a = 1'b1;
    tick(); check_out("unfreeze1", 1'b0, 2, int'(c_a[2]), 1'b0);
    tick(); check_out("unfreeze2", 1'b0, 2, int'(c_a[2]), 1'b0);
    tick(); check_out("unfreeze3", 1'b0, 3, int'(c_a[3]), 1'b1);

    // Asynchronous reset between edges while scanning on channel 3.
    #2 rst = 1'b1;
    #1 check_out("async_rst", 1'b0, 0, 0, 1'b0);
    tick();
    rst = 1'b0; mode_a = 1'b0; s_a = 2'd2; en_a = 1'b1;
    tick(); check_out("post_rst", 1'b0, 2, int'(c_a[2]), 1'b1);

    // SCAN at 1 -> MANUAL s=3 -> SCAN holds 3 for 4 cycles then wraps.
    c_a = 4'b0101; s_a = 2'd1;
    tick(); check_out("m2s_a", 1'b0, 1, 0, 1'b1);
    mode_a = 1'b1;
    tick(); check_out("m2s_b", 1'b0, 1, 0, 1'b0);
    mode_a = 1'b0; s_a = 2'd3;
    tick(); check_out("s2m", 1'b0, 3, 0, 1'b1);
    mode_a = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i <= 4) check_out($sformatf("rescan%0d", i), 1'b0, 3, 0, 1'b0);
      else        check_out("rescan_wrap", 1'b0, 0, 1, 1'b1);
    end

    // Mode change together with en=0: select stays frozen.
    mode_a = 1'b0; en_a = 1'b0; s_a = 2'd2;
    tick(); check_out("modechg_frozen", 1'b0, 0, 1, 1'b0);
    en_a = 1'b1;
    tick(); check_out("modechg_resume", 1'b0, 2, 1, 1'b1);

    // Randomized traffic on both instances against the reference model.
    // Mode toggles only on enabled cycles.
    mode_a = 1'b0; en_a = 1'b0; mode_b = 1'b0; en_b = 1'b0;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      m_sel[k] = 0; m_base[k] = 0; m_ticks[k] = 0; m_prev[k] = 1'b0;
    end
    for (int i = 0; i < 400; i++) begin
      en_a = ($urandom_range(0, 3) != 0);
      if (en_a && $urandom_range(0, 9) == 0) mode_a = ~mode_a;
      s_a = 2'($urandom_range(0, 3));
      c_a = 4'($urandom_range(0, 15));
      en_b = ($urandom_range(0, 3) != 0);
      if (en_b && $urandom_range(0, 9) == 0) mode_b = ~mode_b;
      s_b = 2'($urandom_range(0, 3));
      c_b = 12'($urandom_range(0, 4095));
      @(posedge clk);
      model_step(0, 4, 4, mode_a, en_a, int'(s_a), st_a);
      model_step(1, 3, 1, mode_b, en_b, int'(s_b), st_b);
      #1;
      check_out($sformatf("rand_a%0d", i), 1'b0, m_sel[0], chan(12'(c_a), m_sel[0], 1), st_a);
      check_out($sformatf("rand_b%0d", i), 1'b1, m_sel[1], chan(c_b, m_sel[1], 4), st_b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
